// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pkg
// Purpose  : Shared types and constants for the pipelined immediate generator.
//            Holds the format codes, RV32I/RV64I opcode constants and the
//            skid-buffer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  // Format codes as presented on fmt_o
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Output skid buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode
// Purpose  : Purely combinational format classification and immediate
//            extraction for one RV32I/RV64I instruction word.
// Ports    : instr - raw 32-bit instruction
//            fmt   - format code (NONE/I/S/B/U/J/Z)
//            imm   - XLEN-wide sign-extended immediate (0 for NONE)
// Macro    : IMM_GEN_PIPE_CSR_EN - enables the Z (CSR uimm) format
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0]  opcode;
  logic [31:0] imm32;
  fmt_e        fmt_sel;

  assign opcode = instr[6:0];

  // Every immediate is first built as a 32-bit value whose bit 31 carries the
  // correct sign (zero for Z), so a single sign extension serves all formats.
  always_comb begin
    fmt_sel = FMT_NONE;
    imm32   = '0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        fmt_sel = FMT_I;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM32: begin
        // Word-sized ALU ops only exist on RV64
        if (XLEN == 64) begin
          fmt_sel = FMT_I;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_sel = FMT_S;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt_sel = FMT_B;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_sel = FMT_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_sel = FMT_J;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_PIPE_CSR_EN
        // Only the immediate CSR forms (funct3[2]=1) carry a uimm in rs1
        if (instr[14]) begin
          fmt_sel = FMT_Z;
          imm32   = {27'b0, instr[19:15]};
        end
`else
        fmt_sel = FMT_NONE;
`endif
      end
      default: begin
        fmt_sel = FMT_NONE;
        imm32   = '0;
      end
    endcase
  end

  assign fmt = fmt_sel;
  assign imm = XLEN'($signed(imm32));

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined immediate generator. Decodes RV32I/RV64I instruction
//            words accepted over valid/ready and presents the registered
//            result through a 2-entry skid buffer so in_ready_o never depends
//            combinationally on out_ready_i.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid_i / in_ready_o / instr_i / tag_i   - input handshake
//            out_valid_o / out_ready_i / imm_o / fmt_o / tag_o - output side
// Macro    : IMM_GEN_PIPE_CSR_EN - enables the Z (CSR uimm) format
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [TAG_W-1:0] tag_o
);

  fmt_e             dec_fmt;
  logic [XLEN-1:0]  dec_imm;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (instr_i),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  skid_state_e      state, state_next;
  logic             take_in, take_out;
  logic             load_head_in, load_head_skid, load_skid;

  // Head entry drives the outputs; skid entry holds the younger word
  logic [XLEN-1:0]  head_imm, skid_imm;
  fmt_e             head_fmt, skid_fmt;
  logic [TAG_W-1:0] head_tag, skid_tag;

  // Both flags decode straight from the state register
  assign in_ready_o  = (state != ST_FULL);
  assign out_valid_o = (state != ST_EMPTY);

  assign take_in  = in_valid_i & in_ready_o;
  assign take_out = out_valid_o & out_ready_i;

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (take_in) begin
          state_next   = ST_ONE;
          load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (take_in && !take_out) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (!take_in && take_out) begin
          state_next = ST_EMPTY;
        end else if (take_in && take_out) begin
          load_head_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (take_out) begin
          state_next     = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      head_imm <= '0;
      head_fmt <= FMT_NONE;
      head_tag <= '0;
      skid_imm <= '0;
      skid_fmt <= FMT_NONE;
      skid_tag <= '0;
    end else begin
      state <= state_next;
      if (load_head_in) begin
        head_imm <= dec_imm;
        head_fmt <= dec_fmt;
        head_tag <= tag_i;
      end else if (load_head_skid) begin
        head_imm <= skid_imm;
        head_fmt <= skid_fmt;
        head_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_tag <= tag_i;
      end
    end
  end

  assign imm_o = head_imm;
  assign fmt_o = head_fmt;
  assign tag_o = head_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe with an XLEN=32 and an
//            XLEN=64 instance. Directed vectors plus backpressure and
//            mid-operation reset sequences.
// Macro    : IMM_GEN_PIPE_CSR_EN - selects expected results for CSRRWI
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // XLEN=32 instance
  logic        iv32, ir32, ov32, or32;
  logic [31:0] instr32;
  logic [3:0]  tagi32, tago32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;

  // XLEN=64 instance
  logic        iv64, ir64, ov64, or64;
  logic [31:0] instr64;
  logic [3:0]  tagi64, tago64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(iv32), .in_ready_o(ir32), .instr_i(instr32), .tag_i(tagi32),
    .out_valid_o(ov32), .out_ready_i(or32),
    .imm_o(imm32), .fmt_o(fmt32), .tag_o(tago32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(iv64), .in_ready_o(ir64), .instr_i(instr64), .tag_i(tagi64),
    .out_valid_o(ov64), .out_ready_i(or64),
    .imm_o(imm64), .fmt_o(fmt64), .tag_o(tago64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          x64;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

`ifdef IMM_GEN_PIPE_CSR_EN
  localparam logic [2:0]  CSR_FMT = 3'd6;
  localparam logic [63:0] CSR_IMM = 64'd1;
`else
  localparam logic [2:0]  CSR_FMT = 3'd0;
  localparam logic [63:0] CSR_IMM = 64'd0;
`endif

  // Single word through one instance with out_ready high; checks 1-cycle latency
  task automatic send_one(input int idx);
    @(negedge clk);
    if (vecs[idx].x64) begin
      iv64 = 1'b1; instr64 = vecs[idx].instr; tagi64 = 4'(idx);
      chk($sformatf("v%0d in_ready", idx), {63'd0, ir64}, 64'd1);
      @(negedge clk);
      iv64 = 1'b0;
      chk($sformatf("v%0d out_valid", idx), {63'd0, ov64}, 64'd1);
      chk($sformatf("v%0d fmt", idx), {61'd0, fmt64}, {61'd0, vecs[idx].fmt});
      chk($sformatf("v%0d imm", idx), imm64, vecs[idx].imm);
      chk($sformatf("v%0d tag", idx), {60'd0, tago64}, 64'(idx));
    end else begin
      iv32 = 1'b1; instr32 = vecs[idx].instr; tagi32 = 4'(idx);
      chk($sformatf("v%0d in_ready", idx), {63'd0, ir32}, 64'd1);
      @(negedge clk);
      iv32 = 1'b0;
      chk($sformatf("v%0d out_valid", idx), {63'd0, ov32}, 64'd1);
      chk($sformatf("v%0d fmt", idx), {61'd0, fmt32}, {61'd0, vecs[idx].fmt});
      chk($sformatf("v%0d imm", idx), {32'd0, imm32}, vecs[idx].imm);
      chk($sformatf("v%0d tag", idx), {60'd0, tago32}, 64'(idx));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h4D62A303, 3'd1, 64'h0000_0000_0000_04D6}; // LW
    vecs[1]  = '{1'b0, 32'hDCA7AF23, 3'd2, 64'h0000_0000_FFFF_FDDE}; // SW, negative
    vecs[2]  = '{1'b0, 32'h18E18F63, 3'd3, 64'h0000_0000_0000_019E}; // BEQ
    vecs[3]  = '{1'b0, 32'h12345017, 3'd4, 64'h0000_0000_1234_5000}; // AUIPC
    vecs[4]  = '{1'b0, 32'hFFDFF06F, 3'd5, 64'h0000_0000_FFFF_FFFC}; // JAL -4
    vecs[5]  = '{1'b0, 32'hFFF00093, 3'd1, 64'h0000_0000_FFFF_FFFF}; // ADDI -1
    vecs[6]  = '{1'b0, 32'h00000033, 3'd0, 64'h0};                   // R-type
    vecs[7]  = '{1'b0, 32'h0010809B, 3'd0, 64'h0};                   // ADDIW on RV32
    vecs[8]  = '{1'b0, 32'h3400D073, CSR_FMT, CSR_IMM};              // CSRRWI
    vecs[9]  = '{1'b1, 32'hFFFFF0B7, 3'd4, 64'hFFFF_FFFF_FFFF_F000}; // LUI RV64
    vecs[10] = '{1'b1, 32'h0010809B, 3'd1, 64'h1};                   // ADDIW RV64
    vecs[11] = '{1'b1, 32'hFFDFF06F, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC}; // JAL RV64

    rst_n = 1'b0;
    iv32 = 1'b0; instr32 = '0; tagi32 = '0; or32 = 1'b1;
    iv64 = 1'b0; instr64 = '0; tagi64 = '0; or64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst out_valid32", {63'd0, ov32}, 64'd0);
    chk("rst in_ready32",  {63'd0, ir32}, 64'd1);
    chk("rst imm32",       {32'd0, imm32}, 64'd0);
    chk("rst fmt32",       {61'd0, fmt32}, 64'd0);
    chk("rst tag32",       {60'd0, tago32}, 64'd0);
    chk("rst out_valid64", {63'd0, ov64}, 64'd0);
    chk("rst imm64",       imm64, 64'd0);

    for (int i = 0; i < NV; i++) send_one(i);

    // Drains after the single-word vectors
    @(negedge clk);
    chk("drained32", {63'd0, ov32}, 64'd0);

    // Backpressure: three back-to-back words with consumer stalled
    or32 = 1'b0;
    iv32 = 1'b1; instr32 = 32'h4D62A303; tagi32 = 4'd1;
    chk("bp accept1 ready", {63'd0, ir32}, 64'd1);
    @(negedge clk);
    tagi32 = 4'd2; instr32 = 32'hDCA7AF23;
    chk("bp accept2 ready", {63'd0, ir32}, 64'd1);
    chk("bp head tag1", {60'd0, tago32}, 64'd1);
    @(negedge clk);
    tagi32 = 4'd3; instr32 = 32'h18E18F63;
    chk("bp full ready", {63'd0, ir32}, 64'd0);
    chk("bp full valid", {63'd0, ov32}, 64'd1);
    @(negedge clk);
    chk("bp stall ready", {63'd0, ir32}, 64'd0);
    chk("bp stall tag",   {60'd0, tago32}, 64'd1);
    chk("bp stall imm",   {32'd0, imm32}, 64'h4D6);
    or32 = 1'b1;
    @(negedge clk);
    chk("bp out tag2",   {60'd0, tago32}, 64'd2);
    chk("bp out imm2",   {32'd0, imm32}, 64'hFFFF_FDDE);
    chk("bp ready again", {63'd0, ir32}, 64'd1);
    @(negedge clk);
    iv32 = 1'b0;
    chk("bp out tag3",  {60'd0, tago32}, 64'd3);
    chk("bp out fmt3",  {61'd0, fmt32}, 64'd3);
    chk("bp valid3",    {63'd0, ov32}, 64'd1);
    @(negedge clk);
    chk("bp empty", {63'd0, ov32}, 64'd0);

    // Reset while FULL
    or32 = 1'b0;
    iv32 = 1'b1; instr32 = 32'h12345017; tagi32 = 4'd5;
    @(negedge clk);
    tagi32 = 4'd6;
    @(negedge clk);
    iv32 = 1'b0;
    chk("prerst full", {63'd0, ir32}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst out_valid", {63'd0, ov32}, 64'd0);
    chk("midrst in_ready",  {63'd0, ir32}, 64'd1);
    chk("midrst tag",       {60'd0, tago32}, 64'd0);
    chk("midrst imm",       {32'd0, imm32}, 64'd0);
    or32 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no stale %0d", k), {63'd0, ov32}, 64'd0);
    end
    send_one(3);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised successor to the combinational immediate generator.
- Accepts raw RV32I/RV64I instruction words over a valid/ready handshake.
- Classifies the format from the opcode; produces an XLEN-wide sign-extended immediate plus a format code.
- Result is registered with a 2-entry skid buffer, so it sits between fetch and decode without breaking the ready path.

Parameters:
XLEN, 32, datapath width of imm_o (32 or 64 only; any other value is an elaboration error).
TAG_W, 4, width of a sideband tag carried alongside each instruction (e.g. ROB/PC index).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset
in_valid_i  input  1  instruction word valid
in_ready_o  output  1  block can accept a word this cycle
instr_i  input  32  raw instruction
tag_i  input  TAG_W  sideband tag
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
imm_o  output  XLEN  sign-extended immediate
fmt_o  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm)
tag_o  output  TAG_W  tag matching imm_o

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n low at a clk edge): both buffer entries empty, out_valid_o=0, imm_o=0, fmt_o=0, tag_o=0, in_ready_o=1 the following cycle.
- Opcode decode (instr[6:0]) selects the format:
  - I: 0000011, 0010011, 1100111; also 0011011 only when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - Z: 1110011, only with the optional feature.
  - Anything else: NONE, imm=0.
- Immediate construction follows the standard RISC-V bit placement.
  - I/S/B/J: sign bit is instr[31], replicated to XLEN.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
- Handshake:
  - Transfer in when in_valid_i & in_ready_o; transfer out when out_valid_o & out_ready_i.
  - in_valid_i must hold stable until accepted.
  - Latency: 1 cycle from accepted input to out_valid_o.
- Skid buffer states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
  - in_ready_o is a registered function of state only, with no combinational path from out_ready_i.
- Transitions:
  - EMPTY -> ONE on input.
  - ONE -> FULL on input without output.
  - ONE -> EMPTY on output without input.
  - ONE -> ONE on simultaneous input and output.
  - FULL -> ONE on output.
- Ordering: strictly FIFO; the output entry is always the oldest.
- Stall: outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Reset mid-operation: contents discarded; no partial results are emitted after reset.

Optional Feature:
Macro IMM_GEN_PIPE_CSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 gives fmt=Z, imm = zero-extended instr[19:15]. Funct3[2]=0 gives fmt=NONE, imm=0.
- Undefined: 1110011 always gives fmt=NONE, imm=0. Format code 6 is never produced.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt enum/localparams (NONE..Z);
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM).
- One sub-module, imm_decode: purely combinational format plus immediate extraction, parametrised by XLEN. The top holds the handshake and skid buffer.

Test Plan:
- XLEN=32, out_ready=1, instr=0x4D62A303 -> next cycle fmt=I, imm=0x000004D6.
- instr=0xDCA7AF23 -> fmt=S, imm=0xFFFFFDDE; instr=0x18E18F63 -> fmt=B, imm=0x0000019E.
- Backpressure:
  - Hold out_ready=0 and issue 3 back-to-back words (tags 1,2,3) -> in_ready falls after 2 accepts, and word 3 waits.
  - Release out_ready -> tags emerge 1,2,3 in order, with no loss or duplication.
- XLEN=64:
  - instr=0xFFFFF0B7 (LUI) -> imm=0xFFFFFFFFFFFFF000.
  - instr=0x0010809B (ADDIW) -> fmt=I, imm=1.
  - Same ADDIW word at XLEN=32 -> fmt=NONE.
- instr=0x3400D073 (CSRRWI):
  - With IMM_GEN_PIPE_CSR_EN -> fmt=Z, imm=1.
  - Without the macro -> fmt=NONE, imm=0.
- Buffer FULL, then rst_n=0 for one edge -> out_valid=0, in_ready=1 next cycle, and no stale outputs afterwards.
